// File: rtl/mem_responder.sv
// Memory responder: word RAM at address 0 plus a write-only framebuffer port.
// Define MEM_RESPONDER_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] FB_BASE     = 32'h0100_0000,
    parameter int          FB_WORDS    = 16384
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_type,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [31:0]                 resp_rdata,
    output logic                        resp_err,
    output logic                        fb_we,
    output logic [$clog2(FB_WORDS)-1:0] fb_addr,
    output logic [3:0]                  fb_be,
    output logic [31:0]                 fb_wdata,
    output logic [1:0]                  dbg_state_o
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam int          FBW     = $clog2(FB_WORDS);
    // Region ends are 33 bits so an end at 2^32 does not wrap to zero.
    localparam logic [32:0] RAM_END = 33'(DEPTH_WORDS) << 2;
    localparam logic [32:0] FB_END  = {1'b0, FB_BASE} + (33'(FB_WORDS) << 2);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with resp_valid && resp_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             fb_we_q, fb_we_d;
    logic [FBW-1:0]   fb_addr_q, fb_addr_d;
    logic [3:0]       fb_be_q, fb_be_d;
    logic [31:0]      fb_wdata_q, fb_wdata_d;
    logic [2:0]       type_q;
    logic [1:0]       off_q;
    logic [31:0]      rd_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             hs, is_load, sz_byte, sz_half, trap, in_ram, in_fb, acc_err;
    logic [31:0]      eff_addr, fb_off, st_data, sh, load_fmt;
    logic [3:0]       st_be;
    logic [AW-1:0]    ram_idx;

    always_comb begin
        hs      = req_valid && (state_q == IDLE);
        is_load = (req_type <= 3'd4);
        sz_byte = (req_type == 3'd0) || (req_type == 3'd3) || (req_type == 3'd5);
        sz_half = (req_type == 3'd1) || (req_type == 3'd4) || (req_type == 3'd6);
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
        trap     = (sz_half && req_addr[0]) || (!sz_byte && !sz_half && (req_addr[1:0] != 2'b00));
        eff_addr = req_addr;
`else
        trap     = 1'b0;
        eff_addr = sz_byte ? req_addr :
                   sz_half ? {req_addr[31:1], 1'b0} : {req_addr[31:2], 2'b00};
`endif
        in_ram  = ({1'b0, eff_addr} < RAM_END);
        in_fb   = (eff_addr >= FB_BASE) && ({1'b0, eff_addr} < FB_END);
        acc_err = trap || !(in_ram || in_fb) || (in_fb && is_load);
        fb_off  = eff_addr - FB_BASE;
        ram_idx = AW'(eff_addr >> 2);
        if (sz_byte) begin
            st_be   = 4'b0001 << eff_addr[1:0];
            st_data = {24'b0, req_wdata[7:0]} << {eff_addr[1:0], 3'b000};
        end else if (sz_half) begin
            st_be   = 4'b0011 << {eff_addr[1], 1'b0};
            st_data = {16'b0, req_wdata[15:0]} << {eff_addr[1], 4'b0000};
        end else begin
            st_be   = 4'hF;
            st_data = req_wdata;
        end
    end

    always_comb begin
        sh = rd_q >> {off_q, 3'b000};
        case (type_q)
            3'd0:    load_fmt = {{24{sh[7]}}, sh[7:0]};
            3'd1:    load_fmt = {{16{sh[15]}}, sh[15:0]};
            3'd3:    load_fmt = {24'b0, sh[7:0]};
            3'd4:    load_fmt = {16'b0, sh[15:0]};
            default: load_fmt = sh;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_be_d    = fb_be_q;
        fb_wdata_d = fb_wdata_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    rdata_d = 32'b0;
                    err_d   = acc_err;
                    state_d = (!acc_err && is_load) ? READ : RESP;
                    if (!acc_err && !is_load && in_fb) begin
                        fb_we_d    = 1'b1;
                        fb_addr_d  = FBW'(fb_off >> 2);
                        fb_be_d    = st_be;
                        fb_wdata_d = st_data;
                    end
                end
            end
            READ: begin
                rdata_d = load_fmt;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rdata_q    <= 32'b0;
            err_q      <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_be_q    <= 4'b0;
            fb_wdata_q <= 32'b0;
            type_q     <= 3'b0;
            off_q      <= 2'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_be_q    <= fb_be_d;
            fb_wdata_q <= fb_wdata_d;
            if (hs) begin
                type_q <= req_type;
                off_q  <= eff_addr[1:0];
            end
        end
    end

    // RAM has no reset: contents survive rst, and a handshake coinciding with rst never writes.
    always_ff @(posedge clk) begin
        if (!rst && hs) rd_q <= mem[ram_idx];
        if (!rst && hs && !acc_err && !is_load && in_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[ram_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_be       = fb_be_q;
    assign fb_wdata    = fb_wdata_q;
    assign dbg_state_o = state_q;
endmodule
